// File: rtl/demux1_2_buf_pkg.sv
// demux1_2_buf shared parameters and types.
// Width/depth defaults live here so every user agrees.
package demux1_2_buf_pkg;

    localparam int DMX_WIDTH = 32;
    localparam int DMX_DEPTH = 2;

    typedef enum logic {
        ROUTE_A = 1'b0,
        ROUTE_B = 1'b1
    } route_e;

endpackage

// File: rtl/demux1_2_buf_sync_fifo.sv
// sync_fifo: one output channel buffer.
// Head word is read straight from storage; storage clears on reset.
module sync_fifo
    import demux1_2_buf_pkg::*;
#(
    parameter int WIDTH = DMX_WIDTH,
    parameter int DEPTH = DMX_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Next pointers and occupancy; pushes into full and pops from empty are dropped.
    always_comb begin
        do_push = push && (cnt_q != FULL);
        do_pop  = pop && (cnt_q != '0);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State and storage update; reset clears everything and wins over push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (do_push) mem_q[wptr_q] <= din;
        end
    end

    assign dout  = mem_q[rptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/demux1_2_buf.sv
// demux1_2_buf: routes one input stream into two buffered channels.
// Ctrl picks the channel; in_ready reflects only that channel's room.
module demux1_2_buf
    import demux1_2_buf_pkg::*;
#(
    parameter int WIDTH = DMX_WIDTH,
    parameter int DEPTH = DMX_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   Ctrl,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       A_data,
    output logic                   A_valid,
    input  logic                   A_ready,
    output logic [WIDTH-1:0]       B_data,
    output logic                   B_valid,
    input  logic                   B_ready,
    output logic [$clog2(DEPTH):0] A_count,
    output logic [$clog2(DEPTH):0] B_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    route_e route;
    logic   push_a, push_b;
    logic   pop_a, pop_b;
    logic   acc;

    // Routing and handshake: no bypass when the selected buffer is full.
    always_comb begin
        route    = route_e'(Ctrl);
        in_ready = (route == ROUTE_B) ? (B_count != FULL)
                                      : (A_count != FULL);
        acc      = in_valid && in_ready;
        push_a   = acc && (route == ROUTE_A);
        push_b   = acc && (route == ROUTE_B);
        pop_a    = A_valid && A_ready;
        pop_b    = B_valid && B_ready;
    end

    assign A_valid = (A_count != '0);
    assign B_valid = (B_count != '0);

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .push  (push_a),
        .pop   (pop_a),
        .din   (in_data),
        .dout  (A_data),
        .count (A_count)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .push  (push_b),
        .pop   (pop_b),
        .din   (in_data),
        .dout  (B_data),
        .count (B_count)
    );

endmodule

// File: doc/demux1_2_buf.md
DEMUX1_2_BUF -- requirements
Module: demux1_2_buf

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits of the input and both output channels.
REQ-002 Parameter DEPTH, default 2: entries per output buffer, power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 in_data  input  WIDTH  word offered for routing.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 Ctrl  input  1  route select: 0 routes to channel A, 1 routes to channel B; sampled together with in_data.
REQ-008 in_ready  output  1  block accepts the offered word this cycle.
REQ-009 A_data  output  WIDTH  head word of channel A buffer.
REQ-010 A_valid  output  1  channel A buffer is non-empty.
REQ-011 A_ready  input  1  channel A consumer takes the head word.
REQ-012 B_data, B_valid, B_ready: same widths and meanings for channel B.
REQ-013 A_count, B_count  output  log2(DEPTH)+1  current occupancy of each buffer.

Function
REQ-014 An input transfer SHALL occur on a clk edge where in_valid=1 and in_ready=1; an output transfer SHALL occur where X_valid=1 and X_ready=1.
REQ-015 in_ready SHALL be combinational: (Ctrl=0 ? A_count<DEPTH : B_count<DEPTH); it SHALL NOT depend on in_valid, A_ready or B_ready.
REQ-016 An accepted word SHALL be written only to the buffer chosen by Ctrl; the other buffer SHALL be unchanged.
REQ-017 Latency SHALL be exactly one cycle: a word accepted at edge N SHALL be visible on X_data with X_valid=1 after edge N when the buffer was empty.
REQ-018 Each buffer SHALL be strict FIFO order; words routed to A SHALL leave A in acceptance order, likewise B.
REQ-019 X_valid SHALL equal (X_count != 0); X_data SHALL be the oldest stored word, and SHALL hold its value while X_valid=1 and X_ready=0.
REQ-020 X_count SHALL increment on push only, decrement on pop only, and remain unchanged on simultaneous push and pop.
REQ-021 Full buffer: with X_count=DEPTH, in_ready SHALL be 0 for that route even if X_ready=1 in the same cycle (no full-bypass); a pop that cycle SHALL still occur.
REQ-022 Empty buffer: X_ready=1 with X_count=0 SHALL have no effect.
REQ-023 Simultaneous push to one channel and pop from the other SHALL both complete in the same cycle.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-025 Ctrl changing while in_valid=1 and in_ready=0 is legal; routing and in_ready SHALL follow the current Ctrl value.

Reset
REQ-026 On reset=1 at a clk edge, all pointers and counts SHALL become 0 and all buffer storage SHALL be cleared to 0.
REQ-027 After reset: A_valid=B_valid=0, A_data=B_data=0, A_count=B_count=0; in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words and override any push or pop in that cycle.

Structure
REQ-029 WIDTH and DEPTH defaults SHALL be defined once in the shared processor parameter include file and referenced from there.
REQ-030 Each channel SHALL be an instance of one sub-module, sync_fifo (clk, reset, push, pop, din, dout, count), instantiated twice; routing and in_ready logic SHALL reside in demux1_2_buf.

Verification
REQ-031 Reset then idle -> A_valid=B_valid=0, A_data=B_data=0, counts 0, in_ready=1.
REQ-032 Push 0x11111111 Ctrl=0, then 0x22222222 Ctrl=1, A_ready=B_ready=1 -> A_data=0x11111111 one cycle after the first push, B_data=0x22222222 one cycle after the second push; each valid for one cycle.
REQ-033 A_ready=0, push 0xA0, 0xA1, 0xA2 with Ctrl=0 -> first two accepted, A_count=2, in_ready=0 on the third; raise A_ready -> A outputs 0xA0 then 0xA1, and 0xA2 is accepted the cycle after the first pop.
REQ-034 A full, Ctrl=1, push 0xB5 -> in_ready=1, B_data=0xB5 next cycle, A contents unchanged.
REQ-035 Stream 10 words 0x0..0x9 to B with B_ready toggling every cycle -> output order 0x0..0x9, no loss or duplication across pointer wrap.
REQ-036 Two words buffered in A and one in B, assert reset for one cycle during a push -> all counts 0, valids 0, data 0 on the next cycle.
